// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: bundle between the timing generator and the video pipeline.
//   run          : downstream -> generator, frame run/stop request
//   hcount/vcount: current pixel position
//   hsync/vsync  : sync outputs, polarity chosen by the generator parameters
//   hblnk/vblnk/de: blanking and data-enable for the position shown
//   pix_en/line_start/frame_start: single-cycle strobes
// master = generator side, slave = consumer side.
interface vga_timing_gen_if #(
    parameter int CNT_W = 11
);
    logic             run;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic             de;
    logic             pix_en;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  run,
        output hcount, vcount, hsync, vsync, hblnk, vblnk, de,
               pix_en, line_start, frame_start
    );

    modport slave (
        output run,
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, de,
               pix_en, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator.
// Produces pixel/line counters, sync, blanking, data-enable and pixel/line/
// frame strobes for the mode set by the parameters. Each pixel lasts PIX_DIV
// clk cycles. run only takes effect on frame boundaries: a stop request lets
// the current frame finish, a start request begins a frame the next cycle.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset (returns to IDLE)
//   vif   : vga_timing_gen_if master (run in, all timing outputs out)
// All outputs are registered together, so every output in a given cycle
// describes the hcount/vcount shown in that same cycle.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int PIX_DIV   = 1,
    parameter int CNT_W     = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vga_timing_gen_if.master      vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PH_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    // Window edges kept one bit wider than the counters so an end edge equal
    // to 2^CNT_W (zero back porch at full range) does not wrap.
    localparam logic [CNT_W:0] H_ACT_E = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] HS_BEG  = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] HS_END  = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] V_ACT_E = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] VS_BEG  = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] VS_END  = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PIX_DIV - 1);

    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end
    if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_pix_div
        $error("vga_timing_gen: PIX_DIV must be 1..16");
    end

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             de_q, de_d;
    logic             pix_en_q, pix_en_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    // Next position/state, then every output decoded from that next position
    // so the registered outputs line up with the registered counters.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        pix_en_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (vif.run) begin
                    state_d  = ACTIVE;
                    pix_en_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (phase_q == PH_LAST) begin
                    phase_d  = '0;
                    pix_en_d = 1'b1;
                    if (hcount_q == H_LAST) begin
                        hcount_d = '0;
                        if (vcount_q == V_LAST) begin
                            vcount_d = '0;
                            // Only frame boundary where run is honoured.
                            if (!vif.run) begin
                                state_d  = IDLE;
                                pix_en_d = 1'b0;
                            end
                        end else begin
                            vcount_d = vcount_q + CNT_W'(1);
                        end
                    end else begin
                        hcount_d = hcount_q + CNT_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            phase_d  = '0;
            hcount_d = '0;
            vcount_d = '0;
        end

        hblnk_d = (state_d == IDLE) || ({1'b0, hcount_d} >= H_ACT_E);
        vblnk_d = (state_d == IDLE) || ({1'b0, vcount_d} >= V_ACT_E);
        de_d    = !hblnk_d && !vblnk_d;

        hsync_d = ~HSYNC_POL;
        vsync_d = ~VSYNC_POL;
        if (state_d == ACTIVE) begin
            if ({1'b0, hcount_d} >= HS_BEG && {1'b0, hcount_d} < HS_END)
                hsync_d = HSYNC_POL;
            // vcount only moves with hcount->0, so vsync follows the same edge.
            if ({1'b0, vcount_d} >= VS_BEG && {1'b0, vcount_d} < VS_END)
                vsync_d = VSYNC_POL;
        end

        line_start_d  = pix_en_d && (hcount_d == '0);
        frame_start_d = line_start_d && (vcount_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            hblnk_q       <= 1'b1;
            vblnk_q       <= 1'b1;
            de_q          <= 1'b0;
            pix_en_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            de_q          <= de_d;
            pix_en_q      <= pix_en_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.hcount      = hcount_q;
    assign vif.vcount      = vcount_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.hblnk       = hblnk_q;
    assign vif.vblnk       = vblnk_q;
    assign vif.de          = de_q;
    assign vif.pix_en      = pix_en_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-mode instances (A: PIX_DIV=1, active-low
// syncs; B: PIX_DIV=4, active-high syncs) driven with random run/reset and
// compared every cycle against a frame-position model (running flag plus a
// cycle offset within the frame, outputs derived arithmetically).
module tb_vga_timing_gen;
    // Instance A mode
    localparam int AHA = 10, AHF = 2, AHS = 3, AHB = 2;
    localparam int AVA = 6,  AVF = 1, AVS = 2, AVB = 1;
    localparam int ADIV = 1;
    localparam int AFRAME = (AHA+AHF+AHS+AHB) * (AVA+AVF+AVS+AVB) * ADIV; // 170
    // Instance B mode
    localparam int BHA = 8, BHF = 1, BHS = 2, BHB = 1;
    localparam int BVA = 4, BVF = 1, BVS = 1, BVB = 1;
    localparam int BDIV = 4;
    localparam int BFRAME = (BHA+BHF+BHS+BHB) * (BVA+BVF+BVS+BVB) * BDIV; // 336

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_W(5)) ifa ();
    vga_timing_gen_if #(.CNT_W(4)) ifb ();

    vga_timing_gen #(
        .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
        .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_DIV(ADIV), .CNT_W(5)
    ) u_dut_a (.clk(clk), .rst_n(rst_n), .vif(ifa));

    vga_timing_gen #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_DIV(BDIV), .CNT_W(4)
    ) u_dut_b (.clk(clk), .rst_n(rst_n), .vif(ifb));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: act = generating frames, t = clk offset inside current frame.
    bit a_act, b_act;
    int a_t, b_t;

    task automatic step(input logic r, input logic run, input int frame,
                        inout bit act, inout int t);
        if (!r) begin
            act = 0; t = 0;
        end else if (!act) begin
            if (run) begin act = 1; t = 0; end
        end else if (t == frame - 1) begin
            if (run) t = 0;
            else begin act = 0; t = 0; end
        end else begin
            t++;
        end
    endtask

    task automatic cmp(input string nm,
                       input int ha, input int hf, input int hs_w, input int hb_w,
                       input int va, input int vf, input int vs_w, input int vb_w,
                       input bit hp, input bit vp, input int div,
                       input bit act, input int t,
                       input int hc, input int vc,
                       input logic hs, input logic vs, input logic hb, input logic vb,
                       input logic de, input logic pe, input logic ls, input logic fs);
        int ht, pix, eh, ev;
        bit ehs, evs, ehb, evb, ede, epe, els, efs;
        ht = ha + hf + hs_w + hb_w;
        if (!act) begin
            eh = 0; ev = 0; ehs = !hp; evs = !vp; ehb = 1; evb = 1;
            ede = 0; epe = 0; els = 0; efs = 0;
        end else begin
            pix = t / div;
            eh  = pix % ht;
            ev  = pix / ht;
            epe = (t % div) == 0;
            ehs = (eh >= ha + hf && eh < ha + hf + hs_w) ? hp : !hp;
            evs = (ev >= va + vf && ev < va + vf + vs_w) ? vp : !vp;
            ehb = eh >= ha;
            evb = ev >= va;
            ede = !ehb && !evb;
            els = epe && eh == 0;
            efs = els && ev == 0;
        end
        chk({nm, ".hcount"},      hc, eh);
        chk({nm, ".vcount"},      vc, ev);
        chk({nm, ".hsync"},       {31'b0, hs}, {31'b0, ehs});
        chk({nm, ".vsync"},       {31'b0, vs}, {31'b0, evs});
        chk({nm, ".hblnk"},       {31'b0, hb}, {31'b0, ehb});
        chk({nm, ".vblnk"},       {31'b0, vb}, {31'b0, evb});
        chk({nm, ".de"},          {31'b0, de}, {31'b0, ede});
        chk({nm, ".pix_en"},      {31'b0, pe}, {31'b0, epe});
        chk({nm, ".line_start"},  {31'b0, ls}, {31'b0, els});
        chk({nm, ".frame_start"}, {31'b0, fs}, {31'b0, efs});
    endtask

    // Free-running frame measurements while run is held high.
    bit meas = 0;
    int cyc = 0;
    int a_last = -1, b_last = -1;
    int a_de = 0, b_de = 0;

    task automatic cycle(input logic r, input logic ra, input logic rb);
        rst_n   = r;
        ifa.run = ra;
        ifb.run = rb;
        @(posedge clk);
        step(r, ra, AFRAME, a_act, a_t);
        step(r, rb, BFRAME, b_act, b_t);
        @(negedge clk);
        cyc++;
        cmp("A", AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, 1'b0, 1'b0, ADIV, a_act, a_t,
            int'(ifa.hcount), int'(ifa.vcount), ifa.hsync, ifa.vsync, ifa.hblnk,
            ifa.vblnk, ifa.de, ifa.pix_en, ifa.line_start, ifa.frame_start);
        cmp("B", BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1'b1, 1'b1, BDIV, b_act, b_t,
            int'(ifb.hcount), int'(ifb.vcount), ifb.hsync, ifb.vsync, ifb.hblnk,
            ifb.vblnk, ifb.de, ifb.pix_en, ifb.line_start, ifb.frame_start);
        if (meas) begin
            if (ifa.frame_start) begin
                if (a_last >= 0) begin
                    chk("A.frame_period", cyc - a_last, AFRAME);
                    chk("A.de_per_frame", a_de, AHA * AVA * ADIV);
                end
                a_last = cyc; a_de = 0;
            end
            if (ifb.frame_start) begin
                if (b_last >= 0) begin
                    chk("B.frame_period", cyc - b_last, BFRAME);
                    chk("B.de_per_frame", b_de, BHA * BVA * BDIV);
                end
                b_last = cyc; b_de = 0;
            end
            a_de += int'(ifa.de);
            b_de += int'(ifb.de);
        end
    endtask

    logic ra, rb, rr;

    initial begin
        rst_n = 1'b0; ifa.run = 1'b1; ifb.run = 1'b1;
        // Reset held with run high: IDLE values throughout.
        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        // Release: frame_start one cycle later, then several whole frames.
        meas = 1;
        repeat (1100) cycle(1'b1, 1'b1, 1'b1);
        meas = 0;
        // Drop run mid-frame: frames finish, then IDLE; pulse short lows too.
        repeat (40) cycle(1'b1, 1'b0, 1'b0);
        repeat (10) cycle(1'b1, 1'b1, 1'b1);
        repeat (400) cycle(1'b1, 1'b0, 1'b0);
        repeat (5) cycle(1'b1, 1'b1, 1'b1);
        // Reset mid-pixel / mid-line.
        repeat (2) cycle(1'b0, 1'b1, 1'b1);
        repeat (200) cycle(1'b1, 1'b1, 1'b1);
        // Random run toggling and sparse resets.
        ra = 1'b1; rb = 1'b1;
        for (int i = 0; i < 14000; i++) begin
            if ($urandom_range(0, 149) == 0) ra = ~ra;
            if ($urandom_range(0, 149) == 0) rb = ~rb;
            rr = ($urandom_range(0, 699) != 0);
            cycle(rr, ra, rb);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator, the successor to the fixed-mode timing block. Produces horizontal/vertical counters, sync, blanking, data-enable and frame/line strobes for any mode set by parameters, with selectable sync polarity, an integer pixel-clock divider and a run/stop control that only starts or stops on frame boundaries. Sits at the head of the video pipeline and feeds every downstream draw stage.

## Interface
- H_ACTIVE, 800: visible pixels per line
- H_FP, 40: horizontal front porch, pixels
- H_SYNC, 128: horizontal sync width, pixels
- H_BP, 88: horizontal back porch, pixels
- V_ACTIVE, 600: visible lines per frame
- V_FP, 1: vertical front porch, lines
- V_SYNC, 4: vertical sync width, lines
- V_BP, 23: vertical back porch, lines
- HSYNC_POL, 1: 1 = hsync active-high, 0 = active-low
- VSYNC_POL, 1: same for vsync
- PIX_DIV, 1: clk cycles per pixel, 1..16
- CNT_W, 11: counter width; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL must be ≤ 2^CNT_W (elaboration-time assertion)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- run  in  1  1 = generate frames; 0 = stop at end of current frame
- hcount  out  CNT_W  horizontal pixel index
- vcount  out  CNT_W  line index
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- hblnk  out  1  hcount ≥ H_ACTIVE
- vblnk  out  1  vcount ≥ V_ACTIVE
- de  out  1  !hblnk && !vblnk
- pix_en  out  1  first clk of each pixel period
- line_start  out  1  pix_en && hcount==0
- frame_start  out  1  pix_en && hcount==0 && vcount==0 in ACTIVE

## Operation
- States: IDLE, ACTIVE. Reset → IDLE.
- IDLE: hcount=vcount=0, hsync/vsync inactive level (!POL), hblnk=vblnk=1, de=0, pix_en=line_start=frame_start=0. run sampled every cycle.
- IDLE with run=1 → ACTIVE; next cycle presents pixel (0,0) with pix_en=line_start=frame_start=1; divider phase = 0.
- ACTIVE: divider counts 0..PIX_DIV-1; pixel advances when phase wraps. hcount 0..H_TOTAL-1, wraps to 0 and increments vcount; vcount 0..V_TOTAL-1, wraps to 0.
- hsync active when H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC; vsync active when V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC. vsync changes only together with hcount→0.
- run=0 in ACTIVE: frame completes unchanged. At the advance from (H_TOTAL-1, V_TOTAL-1): run=0 → IDLE (IDLE values next cycle, no frame_start); run=1 → (0,0) with frame_start. run sampled only at that point; toggles mid-frame have no effect.
- rst_n=0 at any point, including mid-frame or mid-pixel: next cycle IDLE values, divider phase 0.
- PIX_DIV=1: pix_en constantly 1 in ACTIVE.

## Timing
- All outputs registered and mutually aligned: for each cycle, hsync/vsync/hblnk/vblnk/de/strobes describe the hcount/vcount shown in that cycle. Zero-cycle skew between them.
- Start latency: run high in IDLE cycle N → frame_start at cycle N+1.
- Each pixel value held exactly PIX_DIV cycles; line = H_TOTAL·PIX_DIV cycles; frame = H_TOTAL·V_TOTAL·PIX_DIV cycles; frame_start period identical.
- Strobes are single-cycle pulses.

## Test plan
- Reset: rst_n=0 for 3 cycles with run=1 → all outputs IDLE values (hblnk=vblnk=1, hsync=vsync=0 for default polarity); rst_n=1 → frame_start one cycle later at (0,0).
- Default mode full frame, PIX_DIV=1: frame_start spacing 1056·628 = 663168 cycles; hsync high exactly hcount 840..967; vsync high exactly vcount 601..604; de high 480000 cycles per frame.
- Wrap: (1055,627) → (0,0) with frame_start=1; (1055,10) → (0,11) with line_start=1, hsync low.
- PIX_DIV=4, small mode (H 8/1/2/1, V 4/1/1/1): each hcount held 4 cycles, pix_en every 4th cycle, frame = 12·7·4 = 336 cycles.
- Stop/start: run=0 at (100,300) → frame completes to (1055,627), next cycle IDLE, no frame_start; run=1 → frame_start next cycle. Pulse run low mid-frame and high again before frame end → no interruption.
- HSYNC_POL=0, VSYNC_POL=0: sync low in sync windows, high elsewhere and in IDLE/reset; rst_n asserted mid-line at hcount 500 → IDLE next cycle.
